// File: rtl/router_fsm_ctrl.sv
// Packet-sequencing FSM for the 1x3 router: steps the register block and
// synchronizer through header decode, payload, full-stall and parity phases.
module router_fsm_ctrl #(
    parameter int ST_W = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    typedef enum logic [ST_W-1:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] addr_q;
    logic [1:0] sel_addr;
    logic       empty_sel;
    logic       soft_hit;
    logic       addr_ok;

    // The header is still on data_in while decoding, so the empty lookup uses it directly there.
    always_comb begin
        sel_addr  = (state == DECODE_ADDRESS) ? data_in : addr_q;
        addr_ok   = (data_in != 2'd3);
        empty_sel = 1'b0;
        soft_hit  = 1'b0;
        case (sel_addr)
            2'd0:    empty_sel = fifo_empty_0;
            2'd1:    empty_sel = fifo_empty_1;
            2'd2:    empty_sel = fifo_empty_2;
            default: empty_sel = 1'b0;
        endcase
        case (addr_q)
            2'd0:    soft_hit = soft_reset_0;
            2'd1:    soft_hit = soft_reset_1;
            2'd2:    soft_hit = soft_reset_2;
            default: soft_hit = 1'b0;
        endcase

        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid && addr_ok)
                    next_state = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    next_state = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    next_state = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    next_state = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    next_state = LOAD_PARITY;
                else
                    next_state = LOAD_DATA;
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_sel)
                    next_state = LOAD_FIRST_DATA;
            end
            default: next_state = DECODE_ADDRESS;
        endcase

        if (soft_hit)
            next_state = DECODE_ADDRESS;
    end

    // Outputs are registered decodes of the upcoming state, so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= DECODE_ADDRESS;
            addr_q        <= 2'd0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            write_enb_reg <= 1'b0;
            rst_int_reg   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && pkt_valid)
                addr_q <= data_in;
            detect_add    <= (next_state == DECODE_ADDRESS);
            lfd_state     <= (next_state == LOAD_FIRST_DATA);
            ld_state      <= (next_state == LOAD_DATA);
            laf_state     <= (next_state == LOAD_AFTER_FULL);
            full_state    <= (next_state == FIFO_FULL_STATE);
            rst_int_reg   <= (next_state == CHECK_PARITY_ERROR);
            write_enb_reg <= (next_state == LOAD_DATA) || (next_state == LOAD_PARITY)
                          || (next_state == LOAD_AFTER_FULL);
            busy          <= !((next_state == DECODE_ADDRESS) || (next_state == LOAD_DATA));
        end
    end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Self-checking bench for router_fsm_ctrl: a phase-level reference model checked
// every cycle, plus directed sequences with literal per-phase output vectors.
module tb_router_fsm_ctrl;

    logic       clk;
    logic       rstn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;

    int errors = 0;
    int checks = 0;

    // Output vector order: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
    localparam logic [7:0] V_DEC = 8'b1000_0000;
    localparam logic [7:0] V_LFD = 8'b0100_0001;
    localparam logic [7:0] V_LD  = 8'b0010_0100;
    localparam logic [7:0] V_LAF = 8'b0001_0101;
    localparam logic [7:0] V_FUL = 8'b0000_1001;
    localparam logic [7:0] V_LP  = 8'b0000_0101;
    localparam logic [7:0] V_CPE = 8'b0000_0011;
    localparam logic [7:0] V_WTE = 8'b0000_0001;

    router_fsm_ctrl #(.ST_W(3)) dut (
        .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] dut_vec();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, busy};
    endfunction

    // Reference model: tracks the packet phase by name and derives outputs from phase rules.
    string      ph = "DEC";
    logic [1:0] m_addr = 2'd0;
    bit         model_ok = 1'b0;

    function automatic logic [7:0] phase_vec(string p);
        logic writing, free;
        writing = (p == "LD") || (p == "LP") || (p == "LAF");
        free    = (p == "DEC") || (p == "LD");
        return {p == "DEC", p == "LFD", p == "LD", p == "LAF", p == "FULL",
                writing, p == "CPE", !free};
    endfunction

    always @(posedge clk) begin
        logic [2:0] empties, softs;
        string      nx;
        empties = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        softs   = {soft_reset_2, soft_reset_1, soft_reset_0};
        if (!rstn) begin
            ph       = "DEC";
            m_addr   = 2'd0;
            model_ok = 1'b1;
        end else begin
            nx = ph;
            if (ph == "DEC") begin
                if (pkt_valid && data_in != 2'd3)
                    nx = empties[data_in] ? "LFD" : "WTE";
            end else if (ph == "LFD") nx = "LD";
            else if (ph == "LD") begin
                if (fifo_full) nx = "FULL";
                else if (!pkt_valid) nx = "LP";
            end else if (ph == "FULL") begin
                if (!fifo_full) nx = "LAF";
            end else if (ph == "LAF") begin
                nx = parity_done ? "DEC" : (low_pkt_valid ? "LP" : "LD");
            end else if (ph == "LP") nx = "CPE";
            else if (ph == "CPE") nx = fifo_full ? "FULL" : "DEC";
            else if (ph == "WTE") begin
                if (m_addr != 2'd3 && empties[m_addr]) nx = "LFD";
            end
            if (m_addr != 2'd3 && softs[m_addr]) nx = "DEC";
            if (ph == "DEC" && pkt_valid) m_addr = data_in;
            ph = nx;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (dut_vec() !== phase_vec(ph)) begin
                errors++;
                $display("[TB] FAIL model_cmp t=%0t phase=%s got=%b exp=%b",
                         $time, ph, dut_vec(), phase_vec(ph));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp);
        checks++;
        if (dut_vec() !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%b exp=%b", name, dut_vec(), exp);
        end
    endtask

    task automatic applyStimulus(input logic pv, input logic [1:0] din,
                                 input logic [2:0] empt, input logic full);
        pkt_valid = pv;
        data_in   = din;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = empt;
        fifo_full = full;
    endtask

    initial begin
        rstn = 1'b0;
        applyStimulus(1'b0, 2'd0, 3'b111, 1'b0);
        {soft_reset_2, soft_reset_1, soft_reset_0} = 3'b000;
        parity_done = 1'b0;
        low_pkt_valid = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'($urandom), 2'($urandom), 3'($urandom), 1'($urandom));
            {soft_reset_2, soft_reset_1, soft_reset_0} = 3'($urandom);
            parity_done = 1'($urandom);
            low_pkt_valid = 1'($urandom);
            cycle();
        end
        checkOutput("reset_state", V_DEC);
        applyStimulus(1'b0, 2'd0, 3'b111, 1'b0);
        {soft_reset_2, soft_reset_1, soft_reset_0} = 3'b000;
        parity_done = 1'b0;
        low_pkt_valid = 1'b0;
        rstn = 1'b1;
        cycle();
        checkOutput("idle_after_reset", V_DEC);

        // Normal packet to port 1
        applyStimulus(1'b1, 2'd1, 3'b010, 1'b0);
        cycle(); checkOutput("pkt1_lfd", V_LFD);
        for (int i = 0; i < 4; i++) begin
            cycle(); checkOutput("pkt1_ld", V_LD);
        end
        pkt_valid = 1'b0;
        cycle(); checkOutput("pkt1_lp", V_LP);
        cycle(); checkOutput("pkt1_cpe", V_CPE);
        cycle(); checkOutput("pkt1_dec", V_DEC);
        cycle(); checkOutput("pkt1_idle", V_DEC);

        // Busy destination on port 2, then full stall inside the payload
        applyStimulus(1'b1, 2'd2, 3'b011, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(); checkOutput("wait_empty", V_WTE);
        end
        fifo_empty_2 = 1'b1;
        cycle(); checkOutput("wait_lfd", V_LFD);
        cycle(); checkOutput("wait_ld", V_LD);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(); checkOutput("stall_full", V_FUL);
        end
        fifo_full = 1'b0;
        cycle(); checkOutput("stall_laf", V_LAF);
        cycle(); checkOutput("stall_back_ld", V_LD);

        // Full and end-of-packet together: full wins
        pkt_valid = 1'b0;
        fifo_full = 1'b1;
        cycle(); checkOutput("full_wins", V_FUL);
        fifo_full = 1'b0;
        low_pkt_valid = 1'b1;
        cycle(); checkOutput("laf_low", V_LAF);
        cycle(); checkOutput("laf_to_lp", V_LP);
        low_pkt_valid = 1'b0;
        fifo_full = 1'b1;
        cycle(); checkOutput("lp_to_cpe", V_CPE);
        cycle(); checkOutput("cpe_to_full", V_FUL);
        fifo_full = 1'b0;
        parity_done = 1'b1;
        cycle(); checkOutput("full_to_laf", V_LAF);
        cycle(); checkOutput("laf_parity_done", V_DEC);
        parity_done = 1'b0;

        // Soft reset: wrong port ignored, addressed port aborts
        applyStimulus(1'b1, 2'd0, 3'b110, 1'b0);
        cycle(); checkOutput("sr_wait", V_WTE);
        soft_reset_1 = 1'b1;
        cycle(); checkOutput("sr_other_ignored", V_WTE);
        soft_reset_1 = 1'b0;
        soft_reset_0 = 1'b1;
        pkt_valid = 1'b0;
        cycle(); checkOutput("sr_own_abort", V_DEC);
        soft_reset_0 = 1'b0;
        cycle(); checkOutput("sr_idle", V_DEC);

        // Invalid address 3 is dropped
        applyStimulus(1'b1, 2'd3, 3'b111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(); checkOutput("addr3_drop", V_DEC);
        end

        // Reset in the middle of a packet
        applyStimulus(1'b1, 2'd1, 3'b111, 1'b0);
        cycle(); checkOutput("mid_lfd", V_LFD);
        cycle(); checkOutput("mid_ld", V_LD);
        rstn = 1'b0;
        soft_reset_1 = 1'b1;
        cycle(); checkOutput("mid_reset", V_DEC);
        rstn = 1'b1;
        soft_reset_1 = 1'b0;
        pkt_valid = 1'b0;
        cycle(); checkOutput("mid_reset_idle", V_DEC);

        // Mixed traffic soak, checked by the model alone
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom),
                          ($urandom_range(0, 3) == 0));
            soft_reset_0 = ($urandom_range(0, 19) == 0);
            soft_reset_1 = ($urandom_range(0, 19) == 0);
            soft_reset_2 = ($urandom_range(0, 19) == 0);
            parity_done = ($urandom_range(0, 3) == 0);
            low_pkt_valid = ($urandom_range(0, 3) == 0);
            cycle();
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
